// File: rtl/delay_meas_pkg.sv
// Shared status encoding, result record and width helper for the
// multi-channel probe delay measurement block.
package delay_meas_pkg;

  // Upper bounds for the result record: CHANNELS <= 16, TS_W <= 64.
  localparam int MAX_CH_W = 4;
  localparam int MAX_TS_W = 64;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_SEQ_ERR = 2'd2,
    ST_RSVD    = 2'd3
  } status_e;

  typedef struct packed {
    logic [MAX_CH_W-1:0] ch;
    logic [MAX_TS_W-1:0] delay;
    status_e             status;
  } res_t;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/delay_meas_fifo.sv
// Synchronous result FIFO; DEPTH must be a power of two (>= 2).
// Storage is not reset, only the pointers are.
module delay_meas_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_wr;
  logic         w_do_rd;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_wr   = i_wr_en && !o_full;
  assign w_do_rd   = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/delay_meas_mch.sv
// Multi-channel probe round-trip delay measurement with a result FIFO.
// Optional per-channel OK-delay statistics when DELAY_MEAS_STATS_EN is defined.
module delay_meas_mch
  import delay_meas_pkg::*;
#(
  parameter  int CHANNELS    = 4,
  parameter  int TS_W        = 32,
  parameter  int SEQ_W       = 8,
  parameter  int TIMEOUT_CYC = 1250000,
  parameter  int RES_DEPTH   = 8,
  localparam int CH_W        = ch_width(CHANNELS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tx_valid_i,
  input  logic [CH_W-1:0]     tx_ch_i,
  input  logic [SEQ_W-1:0]    tx_seq_i,
  input  logic                rx_valid_i,
  input  logic [CH_W-1:0]     rx_ch_i,
  input  logic [SEQ_W-1:0]    rx_seq_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [CH_W-1:0]     res_ch_o,
  output logic [TS_W-1:0]     res_delay_o,
  output logic [1:0]          res_status_o,
  output logic [CHANNELS-1:0] ovr_o,
  input  logic                ovr_clr_i,
  output logic [15:0]         drop_cnt_o
`ifdef DELAY_MEAS_STATS_EN
  ,
  input  logic [CH_W-1:0]     stat_ch_i,
  output logic [TS_W-1:0]     stat_min_o,
  output logic [TS_W-1:0]     stat_max_o,
  output logic [31:0]         stat_cnt_o,
  input  logic                stat_clr_i
`endif
);

  localparam logic [TS_W-1:0] TMO  = TS_W'(TIMEOUT_CYC);
  localparam int              FW   = CH_W + TS_W + 2;

  logic [TS_W-1:0]     r_ts;
  logic [CHANNELS-1:0] r_wait;
  logic [CHANNELS-1:0] r_pend;
  logic [CHANNELS-1:0] r_ovr;
  logic [TS_W-1:0]     r_start [CHANNELS];
  logic [SEQ_W-1:0]    r_seq   [CHANNELS];
  logic [15:0]         r_drop;
  res_t                r_res_p0;
  logic                r_vld_p0;

  logic [TS_W-1:0]     w_elapsed [CHANNELS];
  logic [CHANNELS-1:0] w_rx_sel;
  logic [CHANNELS-1:0] w_tx_sel;
  logic [CHANNELS-1:0] w_match;
  logic [CHANNELS-1:0] w_tmo;
  logic [CHANNELS-1:0] w_ovr_set;
  logic [CHANNELS-1:0] w_wait_nx;
  logic [CHANNELS-1:0] w_pick;
  logic [TS_W-1:0]     w_ok_delay;
  res_t                w_cand;
  logic                w_cand_vld;
  logic                w_full;
  logic                w_empty;
  logic [FW-1:0]       w_rd;
  logic                w_unused;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) w_elapsed[i] = r_ts - r_start[i];
  end

  // Per-channel event resolution: rx first, then timeout, then tx.
  always_comb begin
    w_rx_sel   = '0;
    w_tx_sel   = '0;
    w_match    = '0;
    w_tmo      = '0;
    w_ovr_set  = '0;
    w_wait_nx  = r_wait;
    w_ok_delay = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_rx_sel[i] = rx_valid_i && (rx_ch_i == CH_W'(i));
      w_tx_sel[i] = tx_valid_i && (tx_ch_i == CH_W'(i));
      w_match[i]  = w_rx_sel[i] && r_wait[i] && (rx_seq_i == r_seq[i]);
      w_tmo[i]    = r_wait[i] && !w_rx_sel[i] && (w_elapsed[i] >= TMO);
      if (w_match[i]) w_ok_delay = w_elapsed[i];
      if (w_tx_sel[i]) begin
        w_wait_nx[i] = 1'b1;
        w_ovr_set[i] = r_wait[i] && !w_match[i] && !w_tmo[i];
      end else if (w_match[i] || w_tmo[i]) begin
        w_wait_nx[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_pick     = '0;
    w_cand     = '0;
    w_cand_vld = 1'b0;
    if (|w_rx_sel) begin
      w_cand_vld   = 1'b1;
      w_cand.ch    = MAX_CH_W'(rx_ch_i);
      w_cand.delay = (|w_match) ? MAX_TS_W'(w_ok_delay) : '0;
      w_cand.status = (|w_match) ? ST_OK : ST_SEQ_ERR;
    end else begin
      // Descending scan so the lowest pending channel is the one kept.
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (r_pend[i]) begin
          w_cand_vld    = 1'b1;
          w_pick        = '0;
          w_pick[i]     = 1'b1;
          w_cand.ch     = MAX_CH_W'(i);
          w_cand.delay  = MAX_TS_W'(TMO);
          w_cand.status = ST_TIMEOUT;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ts     <= '0;
      r_wait   <= '0;
      r_pend   <= '0;
      r_ovr    <= '0;
      r_vld_p0 <= 1'b0;
      r_drop   <= '0;
    end else begin
      r_ts     <= r_ts + TS_W'(1);
      r_wait   <= w_wait_nx;
      r_pend   <= (r_pend & ~w_pick) | w_tmo;
      r_ovr    <= (ovr_clr_i ? '0 : r_ovr) | w_ovr_set;
      r_vld_p0 <= w_cand_vld;
      if (r_vld_p0 && w_full && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    r_res_p0 <= w_cand;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_tx_sel[i]) begin
        r_start[i] <= r_ts;
        r_seq[i]   <= tx_seq_i;
      end
    end
  end

  // p0 -> FIFO write; a full FIFO discards the result.
  delay_meas_fifo #(
    .W     (FW),
    .DEPTH (RES_DEPTH)
  ) u_fifo (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_wr_en   (r_vld_p0),
    .i_wr_data ({r_res_p0.ch[CH_W-1:0], r_res_p0.delay[TS_W-1:0], r_res_p0.status}),
    .i_rd_en   (res_ready_i),
    .o_rd_data (w_rd),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign w_unused     = ^{r_res_p0.ch, r_res_p0.delay};
  assign res_valid_o  = !w_empty;
  assign res_ch_o     = w_empty ? '0 : w_rd[TS_W+2 +: CH_W];
  assign res_delay_o  = w_empty ? '0 : w_rd[2 +: TS_W];
  assign res_status_o = w_empty ? '0 : w_rd[1:0];
  assign ovr_o        = r_ovr;
  assign drop_cnt_o   = r_drop;

`ifdef DELAY_MEAS_STATS_EN
  logic [TS_W-1:0] r_min [CHANNELS];
  logic [TS_W-1:0] r_max [CHANNELS];
  logic [31:0]     r_cnt [CHANNELS];

  // Statistics track every OK result at the FIFO write, dropped or not.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_min[i] <= '1;
        r_max[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else if (stat_clr_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_min[i] <= '1;
        r_max[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else if (r_vld_p0 && (r_res_p0.status == ST_OK)) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (r_res_p0.ch[CH_W-1:0] == CH_W'(i)) begin
          if (r_res_p0.delay[TS_W-1:0] < r_min[i]) r_min[i] <= r_res_p0.delay[TS_W-1:0];
          if (r_res_p0.delay[TS_W-1:0] > r_max[i]) r_max[i] <= r_res_p0.delay[TS_W-1:0];
          if (r_cnt[i] != 32'hFFFF_FFFF) r_cnt[i] <= r_cnt[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    stat_min_o = '0;
    stat_max_o = '0;
    stat_cnt_o = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (stat_ch_i == CH_W'(i)) begin
        stat_min_o = r_min[i];
        stat_max_o = r_max[i];
        stat_cnt_o = r_cnt[i];
      end
    end
  end
`endif

endmodule
